// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - decode stage bus: fetch input, execute output, regfile read, load writeback
//
// Groups every decode-stage signal except clk/nreset.
//   slave  : the decode stage itself
//   master : the surrounding pipeline (fetch, execute, regfile, writeback)
interface decode_stage_if #(
    parameter int BIT_WIDTH    = 32,
    parameter int REG_COUNT_L2 = 4
);
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [BIT_WIDTH-1:0]    in_inst;
    logic [BIT_WIDTH-1:0]    in_pc;
    logic                    out_valid;
    logic                    out_ready;
    logic [BIT_WIDTH-1:0]    out_inst;
    logic [BIT_WIDTH-1:0]    out_Rn_value;
    logic [BIT_WIDTH-1:0]    out_Rd_Rm_value;
    logic                    out_stall;
    logic [REG_COUNT_L2-1:0] rf_read_addr1;
    logic [REG_COUNT_L2-1:0] rf_read_addr2;
    logic [BIT_WIDTH-1:0]    rf_read_value1;
    logic [BIT_WIDTH-1:0]    rf_read_value2;
    logic                    wb_valid;
    logic [REG_COUNT_L2-1:0] wb_addr;
    logic [BIT_WIDTH-1:0]    wb_value;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
               rf_read_value1, rf_read_value2, wb_valid, wb_addr, wb_value,
        output in_ready, out_valid, out_inst, out_Rn_value, out_Rd_Rm_value,
               out_stall, rf_read_addr1, rf_read_addr2
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
               rf_read_value1, rf_read_value2, wb_valid, wb_addr, wb_value,
        input  in_ready, out_valid, out_inst, out_Rn_value, out_Rd_Rm_value,
               out_stall, rf_read_addr1, rf_read_addr2
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-entry decode stage with operand read and load-use hazard detection
//
// Ports:
//   clk     : clock
//   nreset  : synchronous, active-high reset
//   bus     : decode_stage_if.slave (fetch in_*, execute out_*, regfile rf_*, load writeback wb_*, flush)
// Optional feature: define DECODE_STAGE_FORWARD_EN to forward wb_value into a held
// operand in the writeback cycle instead of waiting for the regfile update.
module decode_stage #(
    parameter int BIT_WIDTH    = 32,
    parameter int REG_COUNT_L2 = 4,
    parameter int PC_INDEX     = 15
) (
    input  logic          clk,
    input  logic          nreset,
    decode_stage_if.slave bus
);
    localparam int AW   = REG_COUNT_L2;
    localparam int NREG = 1 << AW;
    localparam logic [AW-1:0] PC_ADDR = AW'(PC_INDEX);

    typedef enum logic [1:0] {EMPTY = 2'd0, HELD = 2'd1, HAZARD = 2'd2} state_t;

    // state_q records occupancy only (EMPTY/HELD); HAZARD is resolved every cycle
    // from the bitmap and the live writeback so a forwarded operand can issue at once.
    state_t               state_q, state_d, cur_state;
    logic [BIT_WIDTH-1:0] inst_q, pc_q;
    logic [NREG-1:0]      pend_q, pend_d;

    logic          occupied, is_data, is_mem, is_ldr, is_str;
    logic          src1_used, src2_used, rm_pc12;
    logic [AW-1:0] src1, src2, rd;
    logic          wb_hit1, wb_hit2, haz1, haz2;
    logic          accept, issue;
    logic [BIT_WIDTH-1:0] op1, op2;

    always_comb begin
        occupied  = (state_q != EMPTY);
        is_data   = (inst_q[27:26] == 2'b00);
        is_mem    = (inst_q[27:26] == 2'b01);
        is_ldr    = is_mem && inst_q[20];
        is_str    = is_mem && !inst_q[20];
        rd        = inst_q[12 +: AW];
        src1      = inst_q[16 +: AW];
        src2      = is_str ? rd : inst_q[0 +: AW];
        src1_used = is_data || is_mem;
        src2_used = (is_data && !inst_q[25]) || (is_ldr && inst_q[25]) || is_str;
        // Data-processing reads of pc through Rm see one extra word of prefetch.
        rm_pc12   = is_data && (src2 == PC_ADDR);

        wb_hit1 = bus.wb_valid && (bus.wb_addr == src1);
        wb_hit2 = bus.wb_valid && (bus.wb_addr == src2);
`ifdef DECODE_STAGE_FORWARD_EN
        haz1 = src1_used && pend_q[src1] && !wb_hit1;
        haz2 = src2_used && pend_q[src2] && !wb_hit2;
`else
        haz1 = src1_used && (pend_q[src1] || wb_hit1);
        haz2 = src2_used && (pend_q[src2] || wb_hit2);
`endif

        if (!occupied)
            cur_state = EMPTY;
        else if (haz1 || haz2)
            cur_state = HAZARD;
        else
            cur_state = HELD;

        if (src1 == PC_ADDR)
            op1 = pc_q + BIT_WIDTH'(8);
`ifdef DECODE_STAGE_FORWARD_EN
        else if (wb_hit1)
            op1 = bus.wb_value;
`endif
        else
            op1 = bus.rf_read_value1;

        if (rm_pc12)
            op2 = pc_q + BIT_WIDTH'(12);
        else if (src2 == PC_ADDR)
            op2 = pc_q + BIT_WIDTH'(8);
`ifdef DECODE_STAGE_FORWARD_EN
        else if (wb_hit2)
            op2 = bus.wb_value;
`endif
        else
            op2 = bus.rf_read_value2;
    end

`ifndef DECODE_STAGE_FORWARD_EN
    logic unused_wb_value;
    assign unused_wb_value = ^bus.wb_value;
`endif

    assign bus.out_valid       = (cur_state == HELD);
    assign bus.out_stall       = (cur_state == HAZARD);
    assign bus.in_ready        = !nreset && !bus.flush && (!occupied || (bus.out_valid && bus.out_ready));
    assign bus.out_inst        = inst_q;
    // Unused operand ports and read addresses are forced to 0 so idle values are deterministic.
    assign bus.out_Rn_value    = (occupied && src1_used) ? op1 : '0;
    assign bus.out_Rd_Rm_value = (occupied && src2_used) ? op2 : '0;
    assign bus.rf_read_addr1   = (occupied && src1_used) ? src1 : '0;
    assign bus.rf_read_addr2   = (occupied && src2_used) ? src2 : '0;

    assign accept = bus.in_valid && bus.in_ready;
    assign issue  = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        if (bus.flush)
            state_d = EMPTY;
        else if (accept)
            state_d = HELD;
        else if (issue)
            state_d = EMPTY;

        // Set is applied after clear so a same-cycle set on the same register wins.
        pend_d = pend_q;
        if (bus.wb_valid)
            pend_d[bus.wb_addr] = 1'b0;
        if (issue && is_ldr)
            pend_d[rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q <= EMPTY;
            inst_q  <= '0;
            pc_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (accept) begin
                inst_q <= bus.in_inst;
                pc_q   <= bus.in_pc;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;
    localparam logic [31:0] I_ADD   = 32'hE0821003;
    localparam logic [31:0] I_SUB   = 32'hE0421003;
    localparam logic [31:0] I_LDR4  = 32'hE5904000;
    localparam logic [31:0] I_USE4  = 32'hE0845004;
    localparam logic [31:0] I_MOVPC = 32'hE1A0000F;
    localparam logic [31:0] I_STRPC = 32'hE58F1000;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] e1;
        logic [31:0] e2;
        bit          u1;
        bit          u2;
    } exp_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic [31:0] rf [16];
    int          total = 0;
    int          bad = 0;

    decode_stage_if #(.BIT_WIDTH(32), .REG_COUNT_L2(4)) bus ();

    decode_stage #(.BIT_WIDTH(32), .REG_COUNT_L2(4), .PC_INDEX(15)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.rf_read_value1 = rf[bus.rf_read_addr1];
        bus.rf_read_value2 = rf[bus.rf_read_addr2];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Architectural operand rules: which registers an instruction reads and what it sees.
    function automatic exp_t model_ops(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        logic [3:0] rn, rd, rm;
        rn = inst[19:16]; rd = inst[15:12]; rm = inst[3:0];
        e.inst = inst; e.u1 = 0; e.u2 = 0; e.e1 = 0; e.e2 = 0;
        if (inst[27:26] == 2'b00) begin
            e.u1 = 1; e.e1 = (rn == 15) ? pc + 8 : rf[rn];
            e.u2 = !inst[25]; e.e2 = (rm == 15) ? pc + 12 : rf[rm];
        end else if (inst[27:26] == 2'b01) begin
            e.u1 = 1; e.e1 = (rn == 15) ? pc + 8 : rf[rn];
            if (inst[20]) begin
                e.u2 = inst[25]; e.e2 = (rm == 15) ? pc + 8 : rf[rm];
            end else begin
                e.u2 = 1; e.e2 = (rd == 15) ? pc + 8 : rf[rd];
            end
        end
        return e;
    endfunction

    task automatic test_reset;
        nreset = 1; bus.flush = 0; bus.in_valid = 1; bus.in_inst = I_ADD; bus.in_pc = 0;
        bus.out_ready = 1; bus.wb_valid = 0; bus.wb_addr = 0; bus.wb_value = 0;
        tick; tick;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        total++; if (bus.out_stall !== 1'b0) begin bad++; $display("FAIL rst_out_stall got %b want 0", bus.out_stall); end
        total++; if (bus.out_inst !== 32'h0) begin bad++; $display("FAIL rst_out_inst got %h want 0", bus.out_inst); end
        total++; if (bus.out_Rn_value !== 32'h0 || bus.out_Rd_Rm_value !== 32'h0) begin
            bad++; $display("FAIL rst_operands got %h/%h want 0/0", bus.out_Rn_value, bus.out_Rd_Rm_value); end
        total++; if (bus.rf_read_addr1 !== 4'h0 || bus.rf_read_addr2 !== 4'h0) begin
            bad++; $display("FAIL rst_rf_addr got %h/%h want 0/0", bus.rf_read_addr1, bus.rf_read_addr2); end
        nreset = 0; bus.in_valid = 0;
        tick;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_add;
        rf[2] = 32'd5; rf[3] = 32'd7;
        bus.in_valid = 1; bus.in_inst = I_ADD; bus.in_pc = 32'h40; bus.out_ready = 1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got %b want 1", bus.in_ready); end
        tick; bus.in_valid = 0; #1;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_out_valid got %b want 1", bus.out_valid); end
        total++; if (bus.out_Rn_value !== 32'd5) begin bad++; $display("FAIL add_rn got %h want 5", bus.out_Rn_value); end
        total++; if (bus.out_Rd_Rm_value !== 32'd7) begin bad++; $display("FAIL add_rm got %h want 7", bus.out_Rd_Rm_value); end
        total++; if (bus.rf_read_addr1 !== 4'd2 || bus.rf_read_addr2 !== 4'd3) begin
            bad++; $display("FAIL add_rf_addr got %h/%h want 2/3", bus.rf_read_addr1, bus.rf_read_addr2); end
        tick;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got %b want 0", bus.out_valid); end
    endtask

    // Resolves a stalled r4 consumer with a writeback of val, then drains it.
    task automatic resolve_r4(input logic [31:0] val, input string tag);
        bus.wb_valid = 1; bus.wb_addr = 4; bus.wb_value = val; #1;
`ifdef DECODE_STAGE_FORWARD_EN
        total++; if (bus.out_valid !== 1'b1 || bus.out_Rn_value !== val || bus.out_Rd_Rm_value !== val) begin
            bad++; $display("FAIL %s_fwd got v=%b %h/%h want v=1 %h", tag, bus.out_valid, bus.out_Rn_value, bus.out_Rd_Rm_value, val); end
`else
        total++; if (bus.out_valid !== 1'b0 || bus.out_stall !== 1'b1) begin
            bad++; $display("FAIL %s_wb_cycle got v=%b s=%b want v=0 s=1", tag, bus.out_valid, bus.out_stall); end
`endif
        tick; rf[4] = val; bus.wb_valid = 0; #1;
`ifdef DECODE_STAGE_FORWARD_EN
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL %s_after got %b want 0", tag, bus.out_valid); end
`else
        total++; if (bus.out_valid !== 1'b1 || bus.out_Rn_value !== val || bus.out_Rd_Rm_value !== val) begin
            bad++; $display("FAIL %s_after got v=%b %h/%h want v=1 %h", tag, bus.out_valid, bus.out_Rn_value, bus.out_Rd_Rm_value, val); end
`endif
        tick;
        total++; if (bus.out_valid !== 1'b0 || bus.out_stall !== 1'b0) begin
            bad++; $display("FAIL %s_drain got v=%b s=%b want 0/0", tag, bus.out_valid, bus.out_stall); end
    endtask

    task automatic issue_load_then_use;
        bus.out_ready = 1; bus.in_valid = 1; bus.in_inst = I_LDR4; bus.in_pc = 32'h200;
        tick;
        bus.in_inst = I_USE4; bus.in_pc = 32'h204; #1;
        total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL ldr_issue got v=%b r=%b want 1/1", bus.out_valid, bus.in_ready); end
        tick; bus.in_valid = 0; #1;
    endtask

    task automatic test_load_use;
        issue_load_then_use;
        for (int i = 0; i < 2; i++) begin
            total++; if (bus.out_stall !== 1'b1 || bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL lu_stall%0d got s=%b v=%b want 1/0", i, bus.out_stall, bus.out_valid); end
            tick;
        end
        resolve_r4(32'h1234, "lu");
    endtask

    task automatic test_pc_read;
        rf[1] = 32'hCAFE0001;
        bus.out_ready = 1; bus.in_valid = 1; bus.in_inst = I_MOVPC; bus.in_pc = 32'h100;
        tick; bus.in_inst = I_STRPC; bus.in_pc = 32'h100; #1;
        total++; if (bus.out_Rd_Rm_value !== 32'h10C) begin bad++; $display("FAIL pc_mov got %h want 10c", bus.out_Rd_Rm_value); end
        tick; bus.in_inst = I_MOVPC; bus.in_pc = 32'hFFFFFFF8; #1;
        total++; if (bus.out_Rn_value !== 32'h108) begin bad++; $display("FAIL pc_str_rn got %h want 108", bus.out_Rn_value); end
        total++; if (bus.out_Rd_Rm_value !== 32'hCAFE0001) begin bad++; $display("FAIL pc_str_rd got %h want cafe0001", bus.out_Rd_Rm_value); end
        tick; bus.in_valid = 0; #1;
        total++; if (bus.out_Rd_Rm_value !== 32'h4) begin bad++; $display("FAIL pc_wrap got %h want 4", bus.out_Rd_Rm_value); end
        tick;
    endtask

    task automatic test_backpressure;
        bus.out_ready = 0; bus.in_valid = 1; bus.in_inst = I_ADD; bus.in_pc = 32'h300;
        tick; bus.in_inst = I_SUB; bus.in_pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold%0d got r=%b v=%b want 0/1", i, bus.in_ready, bus.out_valid); end
            total++; if (bus.out_inst !== I_ADD || bus.out_Rn_value !== rf[2] || bus.out_Rd_Rm_value !== rf[3]) begin
                bad++; $display("FAIL bp_stable%0d got %h %h/%h want %h %h/%h", i, bus.out_inst,
                                bus.out_Rn_value, bus.out_Rd_Rm_value, I_ADD, rf[2], rf[3]); end
            tick;
        end
        bus.out_ready = 1; #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got %b want 1", bus.in_ready); end
        tick; bus.in_valid = 0; #1;
        total++; if (bus.out_inst !== I_SUB || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_next got %h v=%b want %h v=1", bus.out_inst, bus.out_valid, I_SUB); end
        tick;
    endtask

    task automatic test_flush;
        issue_load_then_use;
        bus.flush = 1; bus.in_valid = 1; bus.in_inst = I_ADD; #1;
        total++; if (bus.out_stall !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL fl_cycle got s=%b r=%b want 1/0", bus.out_stall, bus.in_ready); end
        tick; bus.flush = 0; bus.in_valid = 0; #1;
        total++; if (bus.out_valid !== 1'b0 || bus.out_stall !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL fl_empty got v=%b s=%b r=%b want 0/0/1", bus.out_valid, bus.out_stall, bus.in_ready); end
        bus.in_valid = 1; bus.in_inst = I_USE4;
        tick; bus.in_valid = 0; #1;
        total++; if (bus.out_stall !== 1'b1) begin bad++; $display("FAIL fl_bitmap_kept got %b want 1", bus.out_stall); end
        resolve_r4(32'h55, "fl");
    endtask

    task automatic test_random;
        exp_t q[$];
        exp_t e;
        logic [31:0] r;
        logic        exp_ready;
        for (int i = 0; i < 15; i++) rf[i] = $urandom;
        for (int c = 0; c < 400; c++) begin
            total++; if (bus.out_valid !== (q.size() != 0) || bus.out_stall !== 1'b0) begin
                bad++; $display("FAIL rnd_valid c%0d got v=%b s=%b want v=%b s=0", c, bus.out_valid, bus.out_stall, q.size() != 0); end
            r = $urandom;
            r[31:28] = 4'hE;
            if (r[27:26] == 2'b01) r[20] = 1'b0;
            bus.in_inst = r; bus.in_pc = $urandom & 32'hFFFFFFFC;
            bus.in_valid = ($urandom % 4) != 0;
            bus.out_ready = ($urandom % 3) != 0;
            #1;
            exp_ready = (q.size() == 0) || bus.out_ready;
            total++; if (bus.in_ready !== exp_ready) begin
                bad++; $display("FAIL rnd_ready c%0d got %b want %b", c, bus.in_ready, exp_ready); end
            if (q.size() != 0 && bus.out_ready) begin
                e = q.pop_front();
                total++; if (bus.out_inst !== e.inst || (e.u1 && bus.out_Rn_value !== e.e1) || (e.u2 && bus.out_Rd_Rm_value !== e.e2)) begin
                    bad++; $display("FAIL rnd_data c%0d got %h %h/%h want %h %h/%h", c, bus.out_inst,
                                    bus.out_Rn_value, bus.out_Rd_Rm_value, e.inst, e.e1, e.e2); end
            end
            if (bus.in_valid && exp_ready) q.push_back(model_ops(bus.in_inst, bus.in_pc));
            tick;
        end
        bus.in_valid = 0; bus.out_ready = 1;
        tick; tick;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + i;
        test_reset;
        test_add;
        test_load_use;
        test_pc_read;
        test_backpressure;
        test_flush;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter BIT_WIDTH, default 32, datapath and instruction width.
REQ-002 Parameter REG_COUNT_L2, default 4, register address width; the pending-load bitmap has 2**REG_COUNT_L2 bits.
REQ-003 Parameter PC_INDEX, default 15, register index that reads as the program counter.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- nreset, in, 1: reset; synchronous, active-high.
- flush, in, 1: discard the held instruction.
- in_valid, in, 1: fetch-side instruction valid.
- in_ready, out, 1: stage accepts in_inst this cycle.
- in_inst, in, BIT_WIDTH: instruction.
- in_pc, in, BIT_WIDTH: fetch address of in_inst.
- out_valid, out, 1: out_* fields valid.
- out_ready, in, 1: execute accepts.
- out_inst, out, BIT_WIDTH: held instruction.
- out_Rn_value, out, BIT_WIDTH: first operand.
- out_Rd_Rm_value, out, BIT_WIDTH: Rd for STR, Rm otherwise.
- out_stall, out, 1: load-use hazard active.
- rf_read_addr1, out, REG_COUNT_L2: regfile read address 1.
- rf_read_addr2, out, REG_COUNT_L2: regfile read address 2.
- rf_read_value1, in, BIT_WIDTH: regfile read data 1, combinational, same cycle.
- rf_read_value2, in, BIT_WIDTH: regfile read data 2, combinational, same cycle.
- wb_valid, in, 1: load writeback strobe.
- wb_addr, in, REG_COUNT_L2: writeback register.
- wb_value, in, BIT_WIDTH: writeback data; visible in the regfile from the next cycle.
REQ-005 Clock is clk; reset is nreset, synchronous, active-high.

Function
REQ-006 Formats are decoded from inst[27:26]: data, memory, branch. Fields: Rn=[19:16], Rd=[15:12], Rm=[3:0], operand-2 immediate=[25], memory register offset=[25], load=[20].
REQ-007 Holding register: one entry, with states EMPTY, HELD and HAZARD.
- Transfer in when in_valid && in_ready.
- in_ready = !flush && (EMPTY || (out_valid && out_ready)).
REQ-008 Source registers:
- data: Rn, plus Rm when operand 2 is a register.
- LDR: Rn, plus Rm when the offset is a register.
- STR: Rn and Rd.
- branch: none.
REQ-009 rf_read_addr1 and rf_read_addr2 are driven from the held instruction's sources. Unused ports drive 0.
REQ-010 Pending-load bitmap:
- Bit Rd is set when an LDR transfers out (out_valid && out_ready).
- Bit wb_addr is cleared on wb_valid.
- If set and clear hit the same register in the same cycle, set wins.
REQ-011 Hazard = any held source has its pending bit set, or wb_valid with wb_addr equal to a held source (the writeback is not yet visible).
- State is HAZARD while the hazard holds, else HELD.
- out_stall = (state == HAZARD).
- out_valid = (state == HELD).
REQ-012 Source equal to PC_INDEX: operand = held pc + 8. For a data instruction whose Rm is PC_INDEX, out_Rd_Rm_value = held pc + 12. Additions wrap modulo 2**BIT_WIDTH.
REQ-013 Latency: an accepted, hazard-free instruction gives out_valid on the next cycle. Throughput is 1 per cycle while out_ready stays high.
REQ-014 While out_valid && !out_ready, out_inst and both operands hold stable.
REQ-015 flush:
- Next state is EMPTY and in_ready is 0 in that cycle; flush wins over a simultaneous in_valid.
- The pending bitmap is not affected.
REQ-016 Branch instructions never hazard. Data and LDR instructions do not hazard on unused Rm.
REQ-017 An unknown format (2'b11) is treated as a branch, with no sources.

Reset
REQ-018 While nreset is 1 at clk: state EMPTY, bitmap all 0, out_valid 0, out_stall 0, out_inst 0, operands 0, rf_read_addr* 0.
REQ-019 Reset mid-hazard discards the held instruction. in_ready is 0 while nreset is 1.

Configuration
REQ-020 Macro DECODE_STAGE_FORWARD_EN.
- Defined: when wb_valid && wb_addr matches a held source, that operand takes wb_value and the match does not hazard. Hazard = pending bit set && !(wb_valid && wb_addr match), so the instruction issues in the writeback cycle.
- Undefined: REQ-011 applies unchanged; the instruction issues one cycle after the writeback.

Verification
REQ-021 Reset: nreset=1 for 2 cycles, in_valid=1 -> in_ready=0, out_valid=0; one cycle after nreset=0, in_ready=1.
REQ-022 ADD r1,r2,r3 (0xE0821003), rf r2=5, r3=7, out_ready=1 -> next cycle out_valid=1, out_Rn_value=5, out_Rd_Rm_value=7.
REQ-023 Load-use: LDR r4,[r0] issues, then ADD r5,r4,r4 -> out_stall=1, out_valid=0 until writeback.
- wb_valid, wb_addr=4, wb_value=0x1234 -> with the macro, out_valid in the same cycle with operands 0x1234.
- Without the macro, out_valid the next cycle.
REQ-024 PC read: MOV r0,pc with in_pc=0x100 -> out_Rd_Rm_value=0x10C; STR r1,[pc] -> out_Rn_value=0x108.
REQ-025 Backpressure: out_ready=0 for 3 cycles -> out_inst and operands stable, in_ready=0; out_ready=1 -> next instruction accepted in the same cycle.
REQ-026 Flush in a HAZARD cycle with in_valid=1 -> state EMPTY next cycle, in_ready=0 in the flush cycle, bitmap bit 4 still 1.
